// File: rtl/dfr_phase_sequencer.sv
// DFR phase sequencer: walks the init/train/test reservoir steps after a start pulse,
// producing input/history addresses and starting the output dot-product once per test sample.
module dfr_phase_sequencer #(
  parameter int ADDR_WIDTH        = 16,
  parameter int CNT_WIDTH         = 32,
  parameter int NUM_VIRTUAL_NODES = 100
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  num_init_steps,
  input  logic [CNT_WIDTH-1:0]  num_train_steps,
  input  logic [CNT_WIDTH-1:0]  num_test_steps,
  input  logic [CNT_WIDTH-1:0]  num_steps_per_sample,
  output logic                  step_req,
  input  logic                  step_ack,
  output logic [ADDR_WIDTH-1:0] input_addr,
  output logic                  history_wr_en,
  output logic [ADDR_WIDTH-1:0] history_addr,
  output logic                  dot_start,
  input  logic                  dot_done,
  output logic [CNT_WIDTH-1:0]  sample_idx,
  output logic [1:0]            phase,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH    = 3'd1,
    S_INIT     = 3'd2,
    S_TRAIN    = 3'd3,
    S_TEST     = 3'd4,
    S_WAIT_DOT = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t               state;
  state_t               adv;
  logic [CNT_WIDTH-1:0] init_n, train_n, test_n, sps_n;
  logic [CNT_WIDTH-1:0] step_cnt, samp_cnt, step_nxt, samp_nxt, phase_len;

  // Next nonzero phase after 'from', falling through to DONE when nothing is left.
  function automatic state_t after_phase(input state_t from,
                                         input logic [CNT_WIDTH-1:0] n_init,
                                         input logic [CNT_WIDTH-1:0] n_train,
                                         input logic [CNT_WIDTH-1:0] n_test);
    state_t r;
    if ((from == S_LATCH) && (n_init != '0)) begin
      r = S_INIT;
    end else if (((from == S_LATCH) || (from == S_INIT)) && (n_train != '0)) begin
      r = S_TRAIN;
    end else if (((from == S_LATCH) || (from == S_INIT) || (from == S_TRAIN)) && (n_test != '0)) begin
      r = S_TEST;
    end else begin
      r = S_DONE;
    end
    return r;
  endfunction

  function automatic logic [1:0] phase_code(input state_t s);
    logic [1:0] p;
    case (s)
      S_INIT:              p = 2'd1;
      S_TRAIN:             p = 2'd2;
      S_TEST, S_WAIT_DOT:  p = 2'd3;
      default:             p = 2'd0;
    endcase
    return p;
  endfunction

  // In LATCH the counts are not registered yet, so decide from the live inputs.
  always_comb begin
    if (state == S_LATCH) begin
      adv = after_phase(state, num_init_steps, num_train_steps, num_test_steps);
    end else begin
      adv = after_phase(state, init_n, train_n, test_n);
    end
  end

  // Latched length of the phase currently being stepped.
  always_comb begin
    case (state)
      S_INIT:  phase_len = init_n;
      S_TRAIN: phase_len = train_n;
      default: phase_len = test_n;
    endcase
  end

  assign step_nxt      = step_cnt + CNT_WIDTH'(1);
  assign samp_nxt      = samp_cnt + CNT_WIDTH'(1);
  // The history write must coincide with the ack itself; abort suppresses it.
  assign history_wr_en = (state == S_TEST) && step_req && step_ack && !abort;

  // Sequencing FSM with registered strobes, counters and status.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state        <= S_IDLE;
      init_n       <= '0;
      train_n      <= '0;
      test_n       <= '0;
      sps_n        <= '0;
      step_cnt     <= '0;
      samp_cnt     <= '0;
      step_req     <= 1'b0;
      input_addr   <= '0;
      history_addr <= '0;
      dot_start    <= 1'b0;
      sample_idx   <= '0;
      phase        <= 2'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
    end else if (abort && (state != S_IDLE)) begin
      state     <= S_IDLE;
      step_req  <= 1'b0;
      dot_start <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      phase     <= 2'd0;
    end else begin
      done      <= 1'b0;
      dot_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LATCH;
            busy    <= 1'b1;
            cfg_err <= 1'b0;
          end
        end
        S_LATCH: begin
          init_n       <= num_init_steps;
          train_n      <= num_train_steps;
          test_n       <= num_test_steps;
          sps_n        <= num_steps_per_sample;
          step_cnt     <= '0;
          samp_cnt     <= '0;
          history_addr <= '0;
          input_addr   <= '0;
          sample_idx   <= '0;
          if ((num_test_steps != '0) && (num_steps_per_sample == '0)) begin
            cfg_err <= 1'b1;
            state   <= S_DONE;
            phase   <= 2'd0;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state <= adv;
            phase <= phase_code(adv);
            done  <= (adv == S_DONE);
            busy  <= (adv != S_DONE);
          end
        end
        S_INIT, S_TRAIN, S_TEST: begin
          // A request is raised from an idle-request cycle, which yields the post-ack gap.
          if (!step_req) begin
            step_req <= 1'b1;
          end else if (step_ack) begin
            step_req   <= 1'b0;
            input_addr <= input_addr + ADDR_WIDTH'(1);
            step_cnt   <= step_nxt;
            if (state == S_TEST) begin
              if (samp_nxt == sps_n) begin
                samp_cnt     <= '0;
                history_addr <= '0;
                dot_start    <= 1'b1;
                state        <= S_WAIT_DOT;
              end else begin
                samp_cnt     <= samp_nxt;
                history_addr <= history_addr + ADDR_WIDTH'(1);
                if (step_nxt == test_n) begin
                  state <= S_DONE;
                  phase <= 2'd0;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                end
              end
            end else if (step_nxt == phase_len) begin
              step_cnt <= '0;
              state    <= adv;
              phase    <= phase_code(adv);
              done     <= (adv == S_DONE);
              busy     <= (adv != S_DONE);
            end
          end
        end
        S_WAIT_DOT: begin
          if (dot_done) begin
            sample_idx <= sample_idx + CNT_WIDTH'(1);
            if (step_cnt != test_n) begin
              state <= S_TEST;
            end else begin
              state <= S_DONE;
              phase <= 2'd0;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dfr_phase_sequencer.sv
// Self-checking bench for dfr_phase_sequencer: directed scenarios plus randomized
// configurations checked against an arithmetic model of the expected run outcome.
module tb_dfr_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [31:0] num_init_steps, num_train_steps, num_test_steps, num_steps_per_sample;
  logic        step_req, step_ack, history_wr_en, dot_start, busy, done, cfg_err;
  logic [15:0] input_addr, history_addr;
  logic [31:0] sample_idx;
  logic [1:0]  phase;
  logic        dot_auto, dot_man;
  wire         dot_done = dot_auto | dot_man;

  int tests = 0;
  int fails = 0;
  int ack_delay = 2, dot_delay = 1;
  bit spur = 1'b0, dot_en = 1'b1;

  int acks = 0, req_cycles = 0, dots = 0, dones = 0;
  int hq[$];
  int pq[$];
  logic [1:0] prev_phase = 2'd0;

  dfr_phase_sequencer dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .abort(abort),
    .num_init_steps(num_init_steps), .num_train_steps(num_train_steps),
    .num_test_steps(num_test_steps), .num_steps_per_sample(num_steps_per_sample),
    .step_req(step_req), .step_ack(step_ack), .input_addr(input_addr),
    .history_wr_en(history_wr_en), .history_addr(history_addr),
    .dot_start(dot_start), .dot_done(dot_done), .sample_idx(sample_idx),
    .phase(phase), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reservoir and dot-product responders, driven just after the rising edge.
  initial begin
    int wcnt, dwait;
    bit dpend;
    step_ack = 1'b0; dot_auto = 1'b0; wcnt = 0; dwait = 0; dpend = 1'b0;
    forever begin
      @(posedge clk); #1;
      step_ack = 1'b0;
      if (step_req) begin
        if (wcnt >= ack_delay) begin step_ack = 1'b1; wcnt = 0; end
        else wcnt++;
      end else begin
        wcnt = 0;
        if (spur && ($urandom_range(0, 3) == 0)) step_ack = 1'b1;
      end
      dot_auto = 1'b0;
      if (dpend) begin
        if (dwait >= dot_delay) begin dot_auto = 1'b1; dpend = 1'b0; end
        else dwait++;
      end else if (dot_start && dot_en) begin
        dpend = 1'b1; dwait = 0;
      end
    end
  end

  // Event log of handshakes, history writes, dot starts, done pulses and phase changes.
  always @(negedge clk) begin
    if (step_req && step_ack && !abort) acks <= acks + 1;
    if (step_req) req_cycles <= req_cycles + 1;
    if (history_wr_en) hq.push_back(int'(history_addr));
    if (dot_start) dots <= dots + 1;
    if (done) dones <= dones + 1;
    if ((phase != prev_phase) && (phase != 2'd0)) pq.push_back(int'(phase));
    prev_phase <= phase;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_step_req", step_req, 0);
    check("rst_hist_wr", history_wr_en, 0);
    check("rst_dot_start", dot_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_input_addr", input_addr, 0);
    check("rst_hist_addr", history_addr, 0);
    check("rst_sample_idx", sample_idx, 0);
    check("rst_phase", phase, 0);
  endtask

  task automatic pulse_start(input int ni, input int ntr, input int nte, input int nsps);
    num_init_steps = ni; num_train_steps = ntr; num_test_steps = nte; num_steps_per_sample = nsps;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full run; expectations are derived from the step counts alone.
  task automatic run_cfg(input int ni, input int ntr, input int nte, input int nsps, input bit repulse);
    int a0, r0, d0, dn0, h0, p0, lat, total, nsamp;
    bit bad;
    int ph_exp[$];
    bad   = (nte != 0) && (nsps == 0);
    total = bad ? 0 : ni + ntr + nte;
    nsamp = bad ? 0 : nte / nsps;
    if (!bad) begin
      if (ni != 0) ph_exp.push_back(1);
      if (ntr != 0) ph_exp.push_back(2);
      if (nte != 0) ph_exp.push_back(3);
    end
    a0 = acks; r0 = req_cycles; d0 = dots; dn0 = dones; h0 = hq.size(); p0 = pq.size();
    pulse_start(ni, ntr, nte, nsps);
    check("busy_rise", busy, 1);
    check("cfg_err_clear", cfg_err, 0);
    lat = 1;
    while (!done && lat < 3000) begin
      start = (repulse && lat == 6) ? 1'b1 : 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    if (total == 0) begin
      check("done_latency", lat, 2);
      check("no_step_req", req_cycles - r0, 0);
    end
    check("busy_at_done", busy, 0);
    check("cfg_err", cfg_err, bad);
    check("ack_count", acks - a0, total);
    check("input_addr", input_addr, total % 65536);
    check("hist_writes", hq.size() - h0, bad ? 0 : nte);
    if (!bad && (hq.size() - h0 == nte)) begin
      for (int k = 0; k < nte; k++) check("hist_addr_seq", hq[h0 + k], k % nsps);
    end
    check("dot_starts", dots - d0, nsamp);
    check("sample_idx", sample_idx, nsamp);
    check("phase_seq_len", pq.size() - p0, ph_exp.size());
    if (pq.size() - p0 == ph_exp.size()) begin
      for (int k = 0; k < ph_exp.size(); k++) check("phase_seq", pq[p0 + k], ph_exp[k]);
    end
    @(negedge clk);
    check("single_done", dones - dn0, 1);
    check("idle_busy", busy, 0);
    check("idle_phase", phase, 0);
    check("idle_done", done, 0);
  endtask

  initial begin
    int n, d0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; dot_man = 1'b0;
    num_init_steps = '0; num_train_steps = '0; num_test_steps = '0; num_steps_per_sample = '0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);

    ack_delay = 2; dot_delay = 1; spur = 1'b0;
    run_cfg(4, 0, 6, 3, 1'b0);
    run_cfg(0, 0, 0, 0, 1'b0);
    run_cfg(0, 0, 5, 0, 1'b0);
    run_cfg(0, 0, 5, 2, 1'b0);
    spur = 1'b1;
    run_cfg(3, 2, 6, 2, 1'b1);

    // Abort while waiting for the dot product, with dot_done in the same cycle.
    spur = 1'b0; dot_en = 1'b0;
    d0 = dots;
    pulse_start(0, 0, 6, 3);
    n = 0;
    while (dots == d0 && n < 500) begin @(negedge clk); n++; end
    check("abort_reach_wait", n < 500, 1);
    repeat (2) @(negedge clk);
    d0 = dones;
    abort = 1'b1; dot_man = 1'b1;
    @(negedge clk);
    abort = 1'b0; dot_man = 1'b0;
    check("abort_phase", phase, 0);
    check("abort_busy", busy, 0);
    check("abort_step_req", step_req, 0);
    check("abort_sample_idx", sample_idx, 0);
    check("abort_input_addr", input_addr, 3);
    repeat (4) @(negedge clk);
    check("abort_no_done", dones - d0, 0);
    check("abort_stays_idle", step_req, 0);
    dot_en = 1'b1;

    // Asynchronous reset in the middle of the test phase.
    pulse_start(2, 0, 6, 3);
    n = 0;
    while (!(phase == 2'd3 && step_req) && n < 500) begin @(negedge clk); n++; end
    check("reset_reach_test", n < 500, 1);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cfg(4, 0, 6, 3, 1'b0);

    for (int it = 0; it < 12; it++) begin
      int ni, ntr, nte, nsps;
      ni   = $urandom_range(0, 5);
      ntr  = $urandom_range(0, 5);
      nte  = $urandom_range(0, 9);
      nsps = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 4);
      ack_delay = $urandom_range(0, 3);
      dot_delay = $urandom_range(0, 3);
      spur = 1'($urandom_range(0, 1));
      run_cfg(ni, ntr, nte, nsps,
              ((ni + ntr + nte) >= 3) && !((nte != 0) && (nsps == 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dfr_phase_sequencer.md
Name: dfr_phase_sequencer

Overview:
Sequences the DFR core through its init, train and test phases after software sets CTRL_REG bit 0. It issues one reservoir step at a time and generates input-memory addresses and reservoir-history write strobes. At every test-sample boundary it starts the output dot-product. It drives the top-level busy flag and sits between the AXI config registers and the reservoir/DAC/XADC datapath.

Parameters:
ADDR_WIDTH, 16, width of input-memory and reservoir-history addresses
CNT_WIDTH, 32, width of all step/sample counters and config inputs
NUM_VIRTUAL_NODES, 100, reservoir nodes; history address space per sample

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse from CTRL_REG bit 0 write
abort  in  1  level; forces return to IDLE
num_init_steps  in  CNT_WIDTH  steps in init phase
num_train_steps  in  CNT_WIDTH  steps in train phase
num_test_steps  in  CNT_WIDTH  steps in test phase
num_steps_per_sample  in  CNT_WIDTH  steps per sample
step_req  out  1  request one reservoir step (DAC write + XADC read)
step_ack  in  1  1-cycle pulse; reservoir step complete
input_addr  out  ADDR_WIDTH  input-memory word address for current step
history_wr_en  out  1  write current reservoir output to history
history_addr  out  ADDR_WIDTH  history word address
dot_start  out  1  1-cycle pulse; start output dot-product
dot_done  in  1  1-cycle pulse; dot-product written
sample_idx  out  CNT_WIDTH  test sample index (output-memory word)
phase  out  2  0 idle, 1 init, 2 train, 3 test
busy  out  1  high from start accept to done
done  out  1  1-cycle pulse at completion
cfg_err  out  1  sticky until next accepted start

Behaviour:
- Reset values: state IDLE. step_req, history_wr_en, dot_start, busy, done and cfg_err are 0. input_addr, history_addr, sample_idx and phase are 0.
- States: IDLE, LATCH, INIT, TRAIN, TEST, WAIT_DOT, DONE.
- IDLE:
  - start=1 → LATCH. busy rises on the next edge.
  - cfg_err clears on an accepted start.
  - start while busy is ignored.
- LATCH (1 cycle):
  - Register all four config inputs; later input changes have no effect.
  - If num_test_steps!=0 and num_steps_per_sample==0: set cfg_err → DONE.
  - Otherwise go to the first phase with a nonzero step count, in order INIT, TRAIN, TEST.
  - If all three counts are 0 → DONE.
- Step handshake (INIT/TRAIN/TEST):
  - step_req is asserted and held until the cycle step_ack=1. It deasserts the cycle after the ack and reasserts the following cycle if steps remain, giving a minimum 2-cycle gap.
  - step_ack while step_req=0 is ignored.
  - On each accepted ack: the phase step counter increments and input_addr increments, wrapping mod 2^ADDR_WIDTH.
  - input_addr is continuous across phases; it is not reset per phase.
- Phase exit: when the phase counter reaches its latched count on an ack, move to the next nonzero phase, or DONE if none remains. The phase counter clears on entry to each phase.
- TEST only: history_wr_en=1 for the same cycle as the accepted step_ack.
  - history_addr = test step index mod num_steps_per_sample. It returns to 0 after each sample.
  - Step count within a sample reaches num_steps_per_sample → WAIT_DOT. dot_start pulses on WAIT_DOT entry.
- WAIT_DOT:
  - No step_req while waiting.
  - On dot_done: sample_idx increments.
  - Then go to TEST if test steps remain, else DONE.
  - A partial last sample (num_test_steps not a multiple) gets no dot_start.
- DONE (1 cycle): done=1 and busy falls the same cycle, then → IDLE. phase=0 in IDLE/DONE. sample_idx holds its value until the next LATCH clears it.
- abort=1 in any non-IDLE state:
  - Next edge → IDLE. All strobes are 0 and busy=0.
  - No done pulse; counters hold for debug.
  - abort has priority over step_ack and dot_done in the same cycle.
- Reset mid-operation: immediate asynchronous return to reset values.

Test Plan:
- init=4, train=0, test=6, steps/sample=3, step_ack 2 cycles after each step_req:
  - 10 acks; input_addr ends at 10; phase sequence 1→3.
  - history_addr sequence 0,1,2,0,1,2.
  - 2 dot_start pulses, sample_idx ends at 2, one done pulse, busy low after.
- init=0, train=0, test=0 → done 2 cycles after start; no step_req; cfg_err=0.
- test=5, steps/sample=0 → cfg_err=1, done pulse, no step_req; the next valid start clears cfg_err.
- test=5, steps/sample=2 → 5 history writes, 2 dot_start pulses, sample_idx=2 (partial sample ignored).
- start re-pulsed mid-run → no effect on counters. abort asserted during WAIT_DOT with dot_done in the same cycle → IDLE, sample_idx unchanged, no done.
- S_AXI_ARESETN low for 1 cycle mid-TEST → all outputs at reset values asynchronously; a fresh start completes the normal run.
